// File: rtl/data_mem_ctrl.sv
// Load/store data-memory controller: byte/half/word, sign/zero-extended loads, misaligned accesses split into two word beats.
// Response 2 cycles after accept (3 if split, 1 on error); req_ready_o is low from accept until the response cycle ends.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  write_en_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  mem_sign_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_q;
  logic             we_q, sign_q, err_q, span_q;
  logic [1:0]       type_q, off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdat_q;
  logic [31:0]      buf0_q, buf1_q;
  logic [31:0]      mem [DEPTH_WORDS];

  // Accept-time decode
  logic                  accept;
  logic [2:0]            size_c;
  logic [31:0]           wmask_c;
  logic [3:0]            end_c;
  logic                  span_c;
  logic [ADDR_WIDTH-3:0] word_c;
  logic                  oob_c, oob1_c, err_c;

  assign accept = req_valid_i && (state_q == IDLE);
  assign word_c = addr_i[ADDR_WIDTH-1:2];

  always_comb begin
    size_c  = 3'd4;
    wmask_c = 32'hFFFF_FFFF;
    case (mem_type_i)
      2'b00: begin size_c = 3'd1; wmask_c = 32'h0000_00FF; end
      2'b01: begin size_c = 3'd2; wmask_c = 32'h0000_FFFF; end
      default: ;
    endcase
  end

  assign end_c  = {2'b00, addr_i[1:0]} + {1'b0, size_c};
  assign span_c = (end_c > 4'd4);
  assign oob_c  = (word_c >= (ADDR_WIDTH-2)'(DEPTH_WORDS));
  assign oob1_c = (word_c >= (ADDR_WIDTH-2)'(DEPTH_WORDS - 1));
  assign err_c  = (mem_type_i == 2'b11) || oob_c || (span_c && oob1_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      span_q  <= 1'b0;
      type_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= write_en_i;
          sign_q  <= mem_sign_i;
          err_q   <= err_c;
          span_q  <= span_c;
          type_q  <= mem_type_i;
          off_q   <= addr_i[1:0];
          idx_q   <= word_c[IDX_W-1:0];
          wdat_q  <= write_data_i[31:0] & wmask_c;
          state_q <= err_c ? RESP : BEAT0;
        end
        BEAT0:   state_q <= span_q ? BEAT1 : RESP;
        BEAT1:   state_q <= RESP;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store data and lane enables laid across two consecutive words
  logic [3:0]       lanes_c;
  logic [7:0]       be_c;
  logic [63:0]      wd_c;
  logic [IDX_W-1:0] idx1_c;

  always_comb begin
    lanes_c = 4'b1111;
    case (type_q)
      2'b00:   lanes_c = 4'b0001;
      2'b01:   lanes_c = 4'b0011;
      default: ;
    endcase
  end

  assign be_c   = {4'b0000, lanes_c} << off_q;
  assign wd_c   = {32'h0, wdat_q} << {off_q, 3'b000};
  assign idx1_c = idx_q + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (state_q == BEAT0) begin
      buf0_q <= mem[idx_q];
      if (we_q)
        for (int b = 0; b < 4; b++)
          if (be_c[b]) mem[idx_q][8*b +: 8] <= wd_c[8*b +: 8];
    end
    if (state_q == BEAT1) begin
      buf1_q <= mem[idx1_c];
      if (we_q)
        for (int b = 0; b < 4; b++)
          if (be_c[4+b]) mem[idx1_c][8*b +: 8] <= wd_c[32+8*b +: 8];
    end
  end

  // Load assembly; buf1 content is irrelevant for non-split loads since it is truncated away
  logic [31:0] lw_c, ext_c;

  assign lw_c = 32'({buf1_q, buf0_q} >> {off_q, 3'b000});

  always_comb begin
    ext_c = lw_c;
    case (type_q)
      2'b00: ext_c = {{24{sign_q & lw_c[7]}}, lw_c[7:0]};
      2'b01: ext_c = {{16{sign_q & lw_c[15]}}, lw_c[15:0]};
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign err_o       = (state_q == RESP) && err_q;
  assign read_data_o = ((state_q == RESP) && !err_q && !we_q) ? DATA_WIDTH'(ext_c) : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl using an expected-response queue.
module tb_data_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam logic [1:0] MT_B = 2'b00, MT_H = 2'b01, MT_W = 2'b10, MT_X = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        write_en_i;
  logic [1:0]  mem_type_i;
  logic        mem_sign_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic        rsp_valid_o;
  logic [31:0] read_data_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .write_en_i   (write_en_i),
    .mem_type_i   (mem_type_i),
    .mem_sign_i   (mem_sign_i),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .read_data_o  (read_data_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one request, then compare the response against the queued expectation.
  task automatic req(input string tag, input logic we, input logic [1:0] mt, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input logic ee, input int el);
    exp_t e;
    int   n;
    bit   seen;
    e.data = ed; e.err = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk_i);
    check({tag, "_ready_idle"}, 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    write_en_i   = we;
    mem_type_i   = mt;
    mem_sign_i   = sg;
    addr_i       = a;
    write_data_i = wd;
    @(posedge clk_i);
    #1;
    req_valid_i  = 1'b0;
    write_en_i   = ~we;
    mem_type_i   = ~mt;
    mem_sign_i   = ~sg;
    addr_i       = $urandom;
    write_data_i = $urandom;
    n = 0;
    seen = 0;
    while (!seen && n < 8) begin
      if (rsp_valid_o) seen = 1;
      else begin
        if (n == 0) check({tag, "_ready_busy"}, 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        n++;
      end
    end
    e = sb.pop_front();
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, n + 1, e.lat);
    check({tag, "_data"}, read_data_o, e.data);
    check({tag, "_err"}, 32'(err_o), 32'(e.err));
    @(posedge clk_i);
    #1;
    check({tag, "_pulse_end"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_data_idle"}, read_data_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; write_en_i = 1'b0; mem_type_i = MT_W;
    mem_sign_i = 1'b0; addr_i = '0; write_data_i = '0;
    #12;
    check("reset_ready", 32'(req_ready_o), 32'd1);
    check("reset_rsp", 32'(rsp_valid_o), 32'd0);
    check("reset_data", read_data_o, 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Aligned word store/load
    req("sw_10", 1, MT_W, 0, 32'h10, 32'h8000_00F1, 32'h0, 0, 2);
    req("lw_10", 0, MT_W, 1, 32'h10, 32'h0, 32'h8000_00F1, 0, 2);

    // Byte store with junk upper bits, signed/unsigned byte loads
    req("sb_13", 1, MT_B, 0, 32'h13, 32'hDEAD_BEAB, 32'h0, 0, 2);
    req("lb_13", 0, MT_B, 1, 32'h13, 32'h0, 32'hFFFF_FFAB, 0, 2);
    req("lbu_13", 0, MT_B, 0, 32'h13, 32'h0, 32'h0000_00AB, 0, 2);
    req("lw_10b", 0, MT_W, 0, 32'h10, 32'h0, 32'hAB00_00F1, 0, 2);

    // Split word store and load
    req("sw_06", 1, MT_W, 0, 32'h06, 32'h1122_3344, 32'h0, 0, 3);
    req("lhu_06", 0, MT_H, 0, 32'h06, 32'h0, 32'h0000_3344, 0, 2);
    req("lhu_08", 0, MT_H, 0, 32'h08, 32'h0, 32'h0000_1122, 0, 2);
    req("lw_06", 0, MT_W, 0, 32'h06, 32'h0, 32'h1122_3344, 0, 3);

    // Split half loads with positive and negative results
    req("sb_07", 1, MT_B, 0, 32'h07, 32'h0000_0080, 32'h0, 0, 2);
    req("sb_08", 1, MT_B, 0, 32'h08, 32'h0000_0012, 32'h0, 0, 2);
    req("lh_07_pos", 0, MT_H, 1, 32'h07, 32'h0, 32'h0000_1280, 0, 3);
    req("sh_07", 1, MT_H, 0, 32'h07, 32'hAAAA_F034, 32'h0, 0, 3);
    req("lh_07_neg", 0, MT_H, 1, 32'h07, 32'h0, 32'hFFFF_F034, 0, 3);
    req("lhu_07", 0, MT_H, 0, 32'h07, 32'h0, 32'h0000_F034, 0, 3);
    req("lbu_09", 0, MT_B, 0, 32'h09, 32'h0, 32'h0000_0011, 0, 2);

    // Range boundaries and illegal type
    req("sb_last", 1, MT_B, 0, 4*DEPTH-1, 32'h0000_005A, 32'h0, 0, 2);
    req("lbu_last", 0, MT_B, 0, 4*DEPTH-1, 32'h0, 32'h0000_005A, 0, 2);
    req("sw_oob", 1, MT_W, 0, 4*DEPTH, 32'hFFFF_FFFF, 32'h0, 1, 1);
    req("lh_span_oob", 0, MT_H, 1, 4*DEPTH-1, 32'h0, 32'h0, 1, 1);
    req("sw_span_oob", 1, MT_W, 0, 4*DEPTH-3, 32'hFFFF_FFFF, 32'h0, 1, 1);
    req("lbu_last_b", 0, MT_B, 0, 4*DEPTH-1, 32'h0, 32'h0000_005A, 0, 2);
    req("st_illegal", 1, MT_X, 0, 32'h10, 32'h1234_5678, 32'h0, 1, 1);
    req("ld_illegal", 0, MT_X, 1, 32'h10, 32'h0, 32'h0, 1, 1);
    req("lw_10c", 0, MT_W, 0, 32'h10, 32'h0, 32'hAB00_00F1, 0, 2);

    // Reset during the second beat of a split load
    @(negedge clk_i);
    req_valid_i = 1'b1; write_en_i = 1'b0; mem_type_i = MT_W; mem_sign_i = 1'b0;
    addr_i = 32'h06; write_data_i = '0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_mid_before", 32'(rsp_valid_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    check("rst_mid_rsp", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("rst_no_rsp_%0d", i), 32'(rsp_valid_o), 32'd0);
    end
    check("rst_after_ready", 32'(req_ready_o), 32'd1);
    req("lw_after_rst", 0, MT_W, 0, 32'h10, 32'h0, 32'hAB00_00F1, 0, 2);

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
